// File: rtl/rv_pkg.sv
// Shared fetch-side types and constants: state enum, entry payload, PC alignment helper.
package rv_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Clear the sub-word bits of a byte address
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~XLEN'(INSTR_BYTES - 1);
  endfunction

endpackage

// File: rtl/rv_fetch_buf.sv
// Two-entry FIFO of fetched {instr, pc}; entry 0 is always the head so the
// head outputs come straight from flops. Flush wins over push and pop.
module rv_fetch_buf
  import rv_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_wdata,
  output fetch_entry_t o_head,
  output logic         o_valid,
  output logic [1:0]   o_count
);

  fetch_entry_t r_ent0;
  fetch_entry_t r_ent1;
  logic [1:0]   r_cnt;
  logic         r_valid;
  logic [1:0]   w_cnt_nxt;

  // Next occupancy from flush/push/pop
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_flush) begin
      w_cnt_nxt = 2'd0;
    end else if (i_push && !i_pop) begin
      w_cnt_nxt = r_cnt + 2'd1;
    end else if (i_pop && !i_push) begin
      w_cnt_nxt = r_cnt - 2'd1;
    end
  end

  // Storage shift/fill and occupancy registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ent0  <= '0;
      r_ent1  <= '0;
      r_cnt   <= 2'd0;
      r_valid <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_valid <= (w_cnt_nxt != 2'd0);
      if (!i_flush) begin
        if (i_pop) begin
          if (i_push && (r_cnt == 2'd1)) begin
            r_ent0 <= i_wdata;
          end else begin
            r_ent0 <= r_ent1;
          end
          if (i_push && (r_cnt == 2'd2)) begin
            r_ent1 <= i_wdata;
          end
        end else if (i_push) begin
          if (r_cnt == 2'd0) begin
            r_ent0 <= i_wdata;
          end else begin
            r_ent1 <= i_wdata;
          end
        end
      end
    end
  end

  assign o_head  = r_ent0;
  assign o_valid = r_valid;
  assign o_count = r_cnt;

endmodule

// File: rtl/rv_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, addresses the combinational
// instruction memory and queues returned words for decode.
// Optional feature macro: RV_FETCH_BOUNDS_EN (fetch-bounds fault and HALT state).
module rv_fetch_ctrl
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned     IMEM_DEPTH = 1024
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            fetch_en_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            instr_valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  input  logic            instr_ready_i,
  output logic            fault_o
);

  localparam int unsigned AW = $clog2(IMEM_DEPTH);

  fetch_state_e    r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_redir_pc;
  logic            w_pop;
  logic            w_push;
  logic            w_oob;
  logic            w_valid;
  logic [1:0]      w_count;
  fetch_entry_t    w_head;
  fetch_entry_t    w_wdata;

  assign w_redir_pc = align_pc(redirect_pc_i);

`ifdef RV_FETCH_BOUNDS_EN
  localparam int unsigned LIMW = XLEN + 1;
  localparam logic [XLEN:0] PC_LIMIT = LIMW'(IMEM_DEPTH) * LIMW'(INSTR_BYTES);

  logic r_fault;
  logic w_redir_ok;

  assign w_oob      = ({1'b0, r_pc} >= PC_LIMIT);
  assign w_redir_ok = ({1'b0, w_redir_pc} < PC_LIMIT);
  assign fault_o    = r_fault;
`else
  assign w_oob   = 1'b0;
  assign fault_o = 1'b0;
`endif

  // A head shown during a redirect is dropped, never handed to decode
  assign w_pop  = w_valid & instr_ready_i & ~redirect_valid_i;
  assign w_push = (r_state == ST_RUN) & fetch_en_i & ~redirect_valid_i & ~w_oob &
                  ((w_count != 2'd2) | w_pop);
  assign w_wdata = '{instr: imem_rdata_i, pc: r_pc};

  // PC sequencing and fetch state machine
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
`ifdef RV_FETCH_BOUNDS_EN
      r_fault <= 1'b0;
`endif
    end else begin
      if (redirect_valid_i) begin
        r_pc <= w_redir_pc;
      end else if (w_push) begin
        r_pc <= r_pc + XLEN'(INSTR_BYTES);
      end
      case (r_state)
        ST_IDLE: begin
          if (fetch_en_i && !redirect_valid_i) begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (redirect_valid_i) begin
            if (!fetch_en_i) begin
              r_state <= ST_IDLE;
            end
`ifdef RV_FETCH_BOUNDS_EN
          end else if (w_oob) begin
            r_state <= ST_HALT;
            r_fault <= 1'b1;
`endif
          end else if (!fetch_en_i) begin
            r_state <= ST_IDLE;
          end
        end
`ifdef RV_FETCH_BOUNDS_EN
        ST_HALT: begin
          if (redirect_valid_i && w_redir_ok) begin
            r_state <= ST_RUN;
            r_fault <= 1'b0;
          end
        end
`endif
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  rv_fetch_buf u_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_valid_i),
    .i_wdata (w_wdata),
    .o_head  (w_head),
    .o_valid (w_valid),
    .o_count (w_count)
  );

  // Word index wraps modulo the memory depth; upper PC bits stay in instr_pc_o
  assign imem_addr_o   = XLEN'(r_pc[AW+1:2]);
  assign instr_valid_o = w_valid;
  assign instr_o       = w_head.instr;
  assign instr_pc_o    = w_head.pc;

endmodule

// File: tb/tb_rv_fetch_ctrl.sv
// Self-checking bench for rv_fetch_ctrl: directed vector table, hand-written
// corner sequences and a randomized run against a queue-based reference model.
module tb_rv_fetch_ctrl;
  import rv_pkg::*;

  localparam int unsigned DEPTH = 1024;
`ifdef RV_FETCH_BOUNDS_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fetch_en_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;
  logic        fault_o;

  logic [31:0] imem [DEPTH];

  always #5 clk = ~clk;

  assign imem_rdata_i = imem[imem_addr_o[9:0]];

  rv_fetch_ctrl #(.RESET_PC(32'h0000_0000), .IMEM_DEPTH(DEPTH)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .fetch_en_i       (fetch_en_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_addr_o      (imem_addr_o),
    .imem_rdata_i     (imem_rdata_i),
    .instr_valid_o    (instr_valid_o),
    .instr_o          (instr_o),
    .instr_pc_o       (instr_pc_o),
    .instr_ready_i    (instr_ready_i),
    .fault_o          (fault_o)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a queue of pending entries, a PC and a mode (0 idle, 1 run, 2 halted)
  fetch_entry_t mq[$];
  logic [31:0]  m_pc;
  int           m_mode;

  function automatic bit in_range(input logic [31:0] pc);
    return pc < DEPTH * 4;
  endfunction

  task automatic m_reset();
    mq.delete();
    m_pc   = 32'h0;
    m_mode = 0;
  endtask

  task automatic m_step(input bit fe, input bit rv, input logic [31:0] rpc, input bit rdy);
    bit take;
    int n0;
    n0   = mq.size();
    take = (n0 != 0) && rdy && !rv;
    if (rv) begin
      mq.delete();
      m_pc = {rpc[31:2], 2'b00};
      if (m_mode == 1 && !fe) m_mode = 0;
      else if (m_mode == 2 && in_range(m_pc)) m_mode = 1;
    end else begin
      if (take) void'(mq.pop_front());
      if (m_mode == 1) begin
        if (BOUNDS && !in_range(m_pc)) begin
          m_mode = 2;
        end else begin
          if (fe && (n0 < 2 || take)) begin
            mq.push_back('{instr: imem[(m_pc >> 2) % DEPTH], pc: m_pc});
            m_pc = m_pc + 32'd4;
          end
          if (!fe) m_mode = 0;
        end
      end else if (m_mode == 0 && fe) begin
        m_mode = 1;
      end
    end
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, ".valid"}, 32'(instr_valid_o), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk({tag, ".pc"}, instr_pc_o, mq[0].pc);
      chk({tag, ".instr"}, instr_o, mq[0].instr);
    end
    chk({tag, ".addr"}, imem_addr_o, (m_pc >> 2) % DEPTH);
    chk({tag, ".fault"}, 32'(fault_o), 32'(m_mode == 2));
  endtask

  // One clock: drive inputs, advance model and DUT, compare after the edge
  task automatic cyc(input bit rst, input bit fe, input bit rv, input logic [31:0] rpc,
                     input bit rdy, input string tag);
    reset_n          = rst;
    fetch_en_i       = fe;
    redirect_valid_i = rv;
    redirect_pc_i    = rpc;
    instr_ready_i    = rdy;
    if (!rst) m_reset();
    else m_step(fe, rv, rpc, rdy);
    @(posedge clk);
    #1;
    cmp_model(tag);
  endtask

  typedef struct {
    bit          rst;
    bit          fe;
    bit          rv;
    logic [31:0] rpc;
    bit          rdy;
    bit          ev;
    logic [31:0] epc;
    logic [31:0] eaddr;
  } vec_t;

  vec_t tv[$];

  task automatic add(input bit rst, fe, rv, input logic [31:0] rpc, input bit rdy,
                     input bit ev, input logic [31:0] epc, input logic [31:0] eaddr);
    tv.push_back('{rst, fe, rv, rpc, rdy, ev, epc, eaddr});
  endtask

  initial begin
    reset_n          = 1'b0;
    fetch_en_i       = 1'b0;
    redirect_valid_i = 1'b0;
    redirect_pc_i    = 32'h0;
    instr_ready_i    = 1'b0;
    for (int k = 0; k < DEPTH; k++) imem[k] = 32'h1000_0000 + 32'(k);
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", 32'(instr_valid_o), 32'h0);
    chk("rst.instr", instr_o, 32'h0);
    chk("rst.pc", instr_pc_o, 32'h0);
    chk("rst.addr", imem_addr_o, 32'h0);
    chk("rst.fault", 32'(fault_o), 32'h0);

    // rst fe rv rpc rdy | valid pc addr
    add(0, 0, 0, 32'h0,   0, 0, 32'h0,   32'h0);
    add(1, 1, 0, 32'h0,   0, 0, 32'h0,   32'h0);
    add(1, 1, 0, 32'h0,   0, 1, 32'h0,   32'h1);
    for (int i = 0; i < 5; i++) add(1, 1, 0, 32'h0, 0, 1, 32'h0, 32'h2);
    add(1, 1, 0, 32'h0,   1, 1, 32'h4,   32'h3);
    add(1, 1, 0, 32'h0,   1, 1, 32'h8,   32'h4);
    add(1, 1, 0, 32'h0,   1, 1, 32'hC,   32'h5);
    add(1, 1, 1, 32'h103, 1, 0, 32'h0,   32'h40);
    add(1, 1, 0, 32'h0,   1, 1, 32'h100, 32'h41);
    add(1, 1, 0, 32'h0,   0, 1, 32'h100, 32'h42);
    add(1, 0, 0, 32'h0,   1, 1, 32'h104, 32'h42);
    add(1, 0, 0, 32'h0,   1, 0, 32'h0,   32'h42);
    add(1, 0, 0, 32'h0,   1, 0, 32'h0,   32'h42);
    add(1, 1, 0, 32'h0,   1, 0, 32'h0,   32'h42);
    add(1, 1, 0, 32'h0,   1, 1, 32'h108, 32'h43);
    add(1, 1, 0, 32'h0,   1, 1, 32'h10C, 32'h44);
    add(1, 0, 0, 32'h0,   1, 0, 32'h0,   32'h44);
    add(1, 0, 1, 32'h20,  1, 0, 32'h0,   32'h8);
    add(1, 0, 0, 32'h0,   1, 0, 32'h0,   32'h8);
    add(1, 1, 0, 32'h0,   1, 0, 32'h0,   32'h8);
    add(1, 1, 0, 32'h0,   1, 1, 32'h20,  32'h9);

    for (int i = 0; i < tv.size(); i++) begin
      cyc(tv[i].rst, tv[i].fe, tv[i].rv, tv[i].rpc, tv[i].rdy, $sformatf("tv%0d", i));
      chk($sformatf("tv%0d.valid", i), 32'(instr_valid_o), 32'(tv[i].ev));
      chk($sformatf("tv%0d.addr", i), imem_addr_o, tv[i].eaddr);
      chk($sformatf("tv%0d.fault", i), 32'(fault_o), 32'h0);
      if (tv[i].ev) begin
        chk($sformatf("tv%0d.pc", i), instr_pc_o, tv[i].epc);
        chk($sformatf("tv%0d.instr", i), instr_o, 32'h1000_0000 + ((tv[i].epc >> 2) % DEPTH));
      end
    end

    // Fetch across the top of the memory
    cyc(1, 1, 1, 32'hFF8, 1, "bnd0");
    chk("bnd0.addr", imem_addr_o, 32'h3FE);
    cyc(1, 1, 0, 32'h0, 1, "bnd1");
    chk("bnd1.pc", instr_pc_o, 32'hFF8);
    cyc(1, 1, 0, 32'h0, 1, "bnd2");
    chk("bnd2.pc", instr_pc_o, 32'hFFC);
    chk("bnd2.instr", instr_o, 32'h1000_03FF);
    cyc(1, 1, 0, 32'h0, 1, "bnd3");
    cyc(1, 1, 0, 32'h0, 1, "bnd4");
`ifdef RV_FETCH_BOUNDS_EN
    chk("bnd4.fault", 32'(fault_o), 32'h1);
    chk("bnd4.valid", 32'(instr_valid_o), 32'h0);
`else
    chk("bnd4.fault", 32'(fault_o), 32'h0);
    chk("bnd4.pc", instr_pc_o, 32'h1004);
    chk("bnd4.instr", instr_o, 32'h1000_0001);
`endif
    cyc(1, 1, 1, 32'h0, 1, "bnd5");
    chk("bnd5.fault", 32'(fault_o), 32'h0);
    cyc(1, 1, 0, 32'h0, 1, "bnd6");
    chk("bnd6.pc", instr_pc_o, 32'h0);
    chk("bnd6.valid", 32'(instr_valid_o), 32'h1);

    // Reset asserted mid-stream takes effect without a clock edge
    reset_n = 1'b0;
    #1;
    chk("arst.valid", 32'(instr_valid_o), 32'h0);
    chk("arst.addr", imem_addr_o, 32'h0);
    cyc(0, 0, 0, 32'h0, 0, "arst");

    // Randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      rpc = (($urandom % 4) == 0) ? $urandom : $urandom_range(0, 32'h1010);
      cyc((i == 1500) ? 1'b0 : 1'b1, ($urandom % 8) != 0, ($urandom % 12) == 0, rpc,
          ($urandom % 4) != 0, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rv_fetch_ctrl.md
# rv_fetch_ctrl

Instruction fetch controller that sequences the combinational-read instruction memory. It owns the program counter and drives the word address into the instruction memory. Each returned word is captured with its PC into a 2-entry buffer, which feeds decode over a valid/ready handshake. Branch/jump redirects flush in-flight instructions and restart fetch at a new PC.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; must be word-aligned.
- `IMEM_DEPTH`, default 1024: instruction memory depth in 32-bit words; power of two.
- `clk` input 1: single clock, rising edge.
- `reset_n` input 1: asynchronous assert, active-low reset.
- `fetch_en_i` input 1: allows new fetches while high.
- `redirect_valid_i` input 1: one-cycle redirect request.
- `redirect_pc_i` input 32: redirect target byte address.
- `imem_addr_o` output 32: word index to instruction memory, equal to {zeros, pc[log2(IMEM_DEPTH)+1:2]}.
- `imem_rdata_i` input 32: instruction word, combinational from `imem_addr_o`.
- `instr_valid_o` output 1: buffer head is valid.
- `instr_o` output 32: buffer head instruction.
- `instr_pc_o` output 32: byte PC of `instr_o`.
- `instr_ready_i` input 1: decode accepts the head this cycle.
- `fault_o` output 1: fetch-bounds fault (see Configuration).

## Operation
- States:
  - IDLE: no fetching.
  - RUN: fetching.
  - HALT: faulted; exists only with the macro.
- Transitions:
  - Reset → IDLE.
  - IDLE → RUN when `fetch_en_i`=1.
  - RUN → IDLE when `fetch_en_i`=0.
  - RUN → HALT on a bounds fault.
  - HALT → RUN on a redirect to an in-range PC.
- Pop: `instr_valid_o & instr_ready_i & ~redirect_valid_i`.
- Capture: state RUN, `fetch_en_i`=1, no redirect, and (count<2 or pop). A capture writes {`imem_rdata_i`, pc} at the buffer tail and sets pc <= pc+4 (32-bit add, wraps at 2^32).
- Full: count=2 with no pop → no capture; pc and `imem_addr_o` hold.
- Simultaneous pop and capture: count unchanged; the head advances and the new entry fills the tail.
- Redirect (highest priority):
  - Buffer is flushed (count <= 0).
  - pc <= {`redirect_pc_i`[31:2], 2'b00}; low two bits are forced to zero.
  - No capture that cycle.
  - A head presented in the redirect cycle is discarded even if `instr_ready_i`=1. Decode must not count it.
  - A redirect in IDLE updates pc and leaves state IDLE.
- `fetch_en_i` low: fetching stops, the buffer keeps draining to decode, and pc holds.
- Buffer order is strict FIFO. `instr_o`/`instr_pc_o` are stable while `instr_valid_o`=1 and not popped.

## Timing
- Reset values:
  - pc = `RESET_PC`, count = 0, state IDLE.
  - `instr_valid_o`=0, `instr_o`=0, `instr_pc_o`=0, `fault_o`=0.
  - `imem_addr_o` is the word index of `RESET_PC`.
- Latency: a word addressed in cycle N (captured at the edge ending N) is on `instr_o` in cycle N+1.
- Redirect in cycle N: the target is addressed in N+1 and valid in N+2.
- Throughput: one instruction per cycle sustained with `instr_ready_i` held high.
- Reset asserted mid-operation: all state returns to reset values asynchronously; buffer contents are lost.

## Configuration
- Macro: `RV_FETCH_BOUNDS_EN`.
- Defined:
  - In RUN, when pc ≥ IMEM_DEPTH*4, no capture occurs and the block enters HALT with `fault_o`=1 the next cycle.
  - Already-buffered entries still drain.
  - A redirect to an in-range PC clears `fault_o` and returns to RUN. A redirect to an out-of-range PC stays in HALT.
- Undefined:
  - `fault_o` is tied 0 and the HALT state is absent.
  - The word index wraps modulo IMEM_DEPTH (pc upper bits are ignored for addressing but kept in `instr_pc_o`).

## Structure
- Shared package `rv_pkg`:
  - Fetch state enum (IDLE/RUN/HALT).
  - `XLEN`=32.
  - `INSTR_BYTES`=4.
  - Fetch entry struct {instr, pc}.
- Sub-module `rv_fetch_buf`: 2-entry FIFO with push, pop and flush inputs and a count output; flush has priority over push.
- The PC/state FSM and the bounds check live in `rv_fetch_ctrl`.

## Test plan
- Reset release with `fetch_en_i`=1, `instr_ready_i`=1, imem[k]=32'h1000_0000+k → `instr_pc_o`=0,4,8,… on consecutive cycles, `instr_o`=imem[pc>>2], first valid 2 cycles after reset deasserts.
- `instr_ready_i`=0 for 5 cycles → `instr_valid_o` stays 1 with head pc=0, buffer holds 0 and 4, `imem_addr_o` stuck at 2; on release, 0,4,8 are delivered in order with no loss or duplicate.
- Redirect to 32'h0000_0103 while the buffer is full → buffer flushed, next valid `instr_pc_o`=32'h100 two cycles later, old entries never appear.
- Redirect and `instr_ready_i` both high in the same cycle → the head is discarded and the next accepted pc equals the redirect target.
- `fetch_en_i` dropped mid-stream → buffered entries drain, then `instr_valid_o`=0; `fetch_en_i` raised again → resumes at the next sequential pc.
- With `RV_FETCH_BOUNDS_EN`, fetch through pc=32'hFFC → pc 32'h1000 raises `fault_o`=1 with no further valid entries; redirect to 0 clears it and resumes at 0. Without the macro, pc 32'h1000 fetches imem[0] with `instr_pc_o`=32'h1000.
